// File: rtl/tb_pulse_sched_pkg.sv
// Shared types and arithmetic helpers for the trackball pulse scheduler.
package tb_pkg;

  typedef enum logic [1:0] {
    MODE_DJOY  = 2'b00,
    MODE_AJOY  = 2'b01,
    MODE_MOUSE = 2'b10,
    MODE_SNAC  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } axis_state_t;

  // Raw request delta width.
  localparam int DELTA_W = 9;
  // Wide working width for the helpers; callers truncate to their own
  // accumulator width (which must be at least DELTA_W+1).
  localparam int CALC_W = 32;

  // Sign-extends a request delta and applies the sensitivity shift.
  function automatic logic signed [CALC_W-1:0] sens_scale(
    input logic [DELTA_W-1:0] delta,
    input logic [1:0]         sens
  );
    logic signed [CALC_W-1:0] ext;
    ext = {{(CALC_W-DELTA_W){delta[DELTA_W-1]}}, delta};
    case (sens)
      2'b00:   sens_scale = ext >>> 2;
      2'b01:   sens_scale = ext >>> 1;
      2'b10:   sens_scale = ext;
      2'b11:   sens_scale = ext <<< 1;
      default: sens_scale = ext;
    endcase
  endfunction

  // Three-term add clamped once to +/-(2^(acc_w-1)-1).
  function automatic logic signed [CALC_W-1:0] sat_add(
    input logic signed [CALC_W-1:0] a,
    input logic signed [CALC_W-1:0] b,
    input logic signed [CALC_W-1:0] step,
    input int                       acc_w
  );
    logic signed [CALC_W-1:0] lim;
    logic signed [CALC_W-1:0] sum;
    lim = (32'sd1 <<< (acc_w - 1)) - 32'sd1;
    sum = a + b + step;
    if (sum > lim) begin
      sat_add = lim;
    end else if (sum < -lim) begin
      sat_add = -lim;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/tb_axis_pulser.sv
// One axis of the scheduler: signed accumulator plus a SETUP/HIGH/LOW
// pulse engine that drains it one unit per emitted clock pulse.
module tb_axis_pulser
  import tb_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int HALF  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add_en,
  input  logic [ACC_W-1:0] add_val,
  output logic             dir_out,
  output logic             clk_out,
  output logic             busy
);

  localparam int PH_W = (HALF > 2) ? $clog2(HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0] PH_ZERO = PH_W'(0);
  localparam logic signed [ACC_W-1:0] ACC_ZERO = ACC_W'(0);

  logic signed [ACC_W-1:0] acc_r;
  axis_state_t             state_r;
  logic [PH_W-1:0]         phase_r;
  logic                    dir_r;
  logic                    clk_r;
  logic                    busy_r;

  logic signed [ACC_W-1:0] acc_s;
  axis_state_t             state_s;
  logic [PH_W-1:0]         phase_s;
  logic                    dir_s;
  logic                    phase_end_s;
  logic                    low_exit_s;
  logic signed [31:0]      add_ext_s;
  logic signed [31:0]      step_ext_s;
  logic                    busy_s;

  // Next accumulator (request plus LOW-exit step, clamped once) and engine state.
  always_comb begin
    phase_end_s = (phase_r == PH_LAST);
    low_exit_s  = (state_r == LOW) && phase_end_s;

    if (add_en) begin
      add_ext_s = {{(32-ACC_W){add_val[ACC_W-1]}}, add_val};
    end else begin
      add_ext_s = 32'sd0;
    end

    // The pulse just finished moved the position one unit in dir_r.
    if (low_exit_s) begin
      step_ext_s = dir_r ? -32'sd1 : 32'sd1;
    end else begin
      step_ext_s = 32'sd0;
    end

    acc_s   = ACC_W'(sat_add({{(32-ACC_W){acc_r[ACC_W-1]}}, acc_r},
                             add_ext_s, step_ext_s, ACC_W));
    state_s = state_r;
    dir_s   = dir_r;
    phase_s = phase_end_s ? PH_ZERO : (phase_r + PH_W'(1));

    if (clear) begin
      acc_s   = ACC_ZERO;
      state_s = IDLE;
      phase_s = PH_ZERO;
      dir_s   = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          phase_s = PH_ZERO;
          if (acc_s != ACC_ZERO) begin
            state_s = SETUP;
            dir_s   = (acc_s > ACC_ZERO);
          end else begin
            state_s = IDLE;
          end
        end
        SETUP: begin
          // Direction follows the accumulator until the pulse is committed.
          dir_s = (acc_s > ACC_ZERO);
          if (phase_end_s) begin
            state_s = HIGH;
          end else begin
            state_s = SETUP;
          end
        end
        HIGH: begin
          if (phase_end_s) begin
            state_s = LOW;
          end else begin
            state_s = HIGH;
          end
        end
        LOW: begin
          if (!phase_end_s) begin
            state_s = LOW;
          end else if (acc_s == ACC_ZERO) begin
            state_s = IDLE;
          end else if ((acc_s > ACC_ZERO) == dir_r) begin
            state_s = HIGH;
          end else begin
            // Sign flipped: re-present the direction before the next pulse.
            state_s = SETUP;
            dir_s   = (acc_s > ACC_ZERO);
          end
        end
        default: begin
          state_s = IDLE;
          phase_s = PH_ZERO;
        end
      endcase
    end

    busy_s = (acc_s != ACC_ZERO) || (state_s != IDLE);
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r   <= ACC_ZERO;
      state_r <= IDLE;
      phase_r <= PH_ZERO;
      dir_r   <= 1'b0;
      clk_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      acc_r   <= acc_s;
      state_r <= state_s;
      phase_r <= phase_s;
      dir_r   <= dir_s;
      clk_r   <= (state_s == HIGH);
      busy_r  <= busy_s;
    end
  end

  assign dir_out = dir_r;
  assign clk_out = clk_r;
  assign busy    = busy_r;

endmodule

// File: rtl/tb_pulse_sched.sv
// Trackball pulse scheduler top: request handshake and scaling, mode-change
// flush, SNAC passthrough mux and the combined busy flag.
module tb_pulse_sched
  import tb_pkg::*;
#(
  parameter int ACC_W = 10,
  parameter int HALF  = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic [1:0] sens,
  input  logic       req_valid,
  input  logic [8:0] req_dx,
  input  logic [8:0] req_dy,
  output logic       req_ready,
  input  logic       v_dir_in,
  input  logic       v_clk_in,
  input  logic       h_dir_in,
  input  logic       h_clk_in,
  output logic       v_dir_out,
  output logic       v_clk_out,
  output logic       h_dir_out,
  output logic       h_clk_out,
  output logic       busy
);

  logic [1:0]       mode_prev_r;
  logic             snac_r;
  logic [3:0]       pt_r;   // {v_dir, v_clk, h_dir, h_clk}

  logic             mode_chg_s;
  logic             clear_s;
  logic             accept_s;
  logic [ACC_W-1:0] h_add_s;
  logic [ACC_W-1:0] v_add_s;
  logic             h_dir_s, h_clk_s, h_busy_s;
  logic             v_dir_s, v_clk_s, v_busy_s;

  // Handshake, flush control and output selection.
  always_comb begin
    req_ready  = ~reset & (mode != MODE_SNAC);
    mode_chg_s = (mode != mode_prev_r);
    // A flush wins over a request landing in the same cycle.
    clear_s    = mode_chg_s | (mode == MODE_SNAC);
    accept_s   = req_valid & req_ready & ~clear_s;
    h_add_s    = ACC_W'(sens_scale(req_dx, sens));
    v_add_s    = ACC_W'(sens_scale(req_dy, sens));

    if (snac_r) begin
      h_clk_out = pt_r[0];
      h_dir_out = pt_r[1];
      v_clk_out = pt_r[2];
      v_dir_out = pt_r[3];
    end else begin
      h_clk_out = h_clk_s;
      h_dir_out = h_dir_s;
      v_clk_out = v_clk_s;
      v_dir_out = v_dir_s;
    end

    busy = h_busy_s | v_busy_s;
  end

  // Previous mode for change detection, and the one-cycle passthrough stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_prev_r <= mode;
      snac_r      <= 1'b0;
      pt_r        <= 4'b0000;
    end else begin
      mode_prev_r <= mode;
      snac_r      <= (mode == MODE_SNAC);
      pt_r        <= {v_dir_in, v_clk_in, h_dir_in, h_clk_in};
    end
  end

  tb_axis_pulser #(.ACC_W(ACC_W), .HALF(HALF)) u_h (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .add_en  (accept_s),
    .add_val (h_add_s),
    .dir_out (h_dir_s),
    .clk_out (h_clk_s),
    .busy    (h_busy_s)
  );

  tb_axis_pulser #(.ACC_W(ACC_W), .HALF(HALF)) u_v (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .add_en  (accept_s),
    .add_val (v_add_s),
    .dir_out (v_dir_s),
    .clk_out (v_clk_s),
    .busy    (v_busy_s)
  );

endmodule

// File: tb/tb_tb_pulse_sched.sv
// Directed plus randomized bench for the trackball pulse scheduler.
module tb_tb_pulse_sched;

  localparam int HALF  = 4;
  localparam int ACC_W = 10;
  localparam int NREC  = 8192;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] sens;
  logic       req_valid;
  logic [8:0] req_dx;
  logic [8:0] req_dy;
  logic       req_ready;
  logic       v_dir_in, v_clk_in, h_dir_in, h_clk_in;
  logic       v_dir_out, v_clk_out, h_dir_out, h_clk_out;
  logic       busy;

  always #5 clk = ~clk;

  tb_pulse_sched #(.ACC_W(ACC_W), .HALF(HALF)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sens      (sens),
    .req_valid (req_valid),
    .req_dx    (req_dx),
    .req_dy    (req_dy),
    .req_ready (req_ready),
    .v_dir_in  (v_dir_in),
    .v_clk_in  (v_clk_in),
    .h_dir_in  (h_dir_in),
    .h_clk_in  (h_clk_in),
    .v_dir_out (v_dir_out),
    .v_clk_out (v_clk_out),
    .h_dir_out (h_dir_out),
    .h_clk_out (h_clk_out),
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int idle_cyc = 0;

  // Pulse records captured by the monitor.
  int   h_rise [NREC];
  int   h_fall [NREC];
  logic h_rdir [NREC];
  int   v_rise [NREC];
  int   v_fall [NREC];
  logic v_rdir [NREC];
  int   h_n = 0;
  int   v_n = 0;
  logic h_prev = 1'b0;
  logic v_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Records every output pulse: start cycle, direction, end cycle.
  always @(negedge clk) begin
    if (h_clk_out === 1'b1 && h_prev === 1'b0) begin
      if (h_n < NREC) begin
        h_rise[h_n] = cyc; h_rdir[h_n] = h_dir_out; h_fall[h_n] = -1;
      end
      h_n++;
    end
    if (h_clk_out === 1'b0 && h_prev === 1'b1 && h_n > 0 && h_n <= NREC) h_fall[h_n-1] = cyc;
    h_prev = h_clk_out;
    if (v_clk_out === 1'b1 && v_prev === 1'b0) begin
      if (v_n < NREC) begin
        v_rise[v_n] = cyc; v_rdir[v_n] = v_dir_out; v_fall[v_n] = -1;
      end
      v_n++;
    end
    if (v_clk_out === 1'b0 && v_prev === 1'b1 && v_n > 0 && v_n <= NREC) v_fall[v_n-1] = cyc;
    v_prev = v_clk_out;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference scaling: arithmetic right shift is floor division.
  function automatic int fdiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q--;
    return q;
  endfunction

  function automatic int scale(input int d, input int s);
    case (s)
      0:       return fdiv(d, 4);
      1:       return fdiv(d, 2);
      2:       return d;
      default: return d * 2;
    endcase
  endfunction

  task automatic send(input int dx, input int dy);
    @(negedge clk);
    req_valid = 1'b1;
    req_dx    = dx[8:0];
    req_dy    = dy[8:0];
    acc_cyc   = cyc;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (busy && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    idle_cyc = cyc;
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  task automatic wait_high(input int budget, input string tag);
    int k;
    k = 0;
    @(negedge clk); #1;
    while (!h_clk_out && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, "_high"}, int'(h_clk_out), 1);
  endtask

  task automatic train_stats(input bit is_h, input int n0, input int n1,
                             output int pos, output int neg, output int badw);
    pos = 0; neg = 0; badw = 0;
    for (int i = n0; i < n1; i++) begin
      if (is_h) begin
        if (h_rdir[i]) pos++; else neg++;
        if (h_fall[i] - h_rise[i] != HALF) badw++;
      end else begin
        if (v_rdir[i]) pos++; else neg++;
        if (v_fall[i] - v_rise[i] != HALF) badw++;
      end
    end
  endtask

  task automatic check_train(input string tag, input bit is_h, input int n0, input int n1,
                             input int exp_pos, input int exp_neg);
    int pos, neg, badw;
    train_stats(is_h, n0, n1, pos, neg, badw);
    check({tag, "_pos"}, pos, exp_pos);
    check({tag, "_neg"}, neg, exp_neg);
    check({tag, "_width"}, badw, 0);
  endtask

  initial begin
    int a, h0, v0, h1, v1;
    int exp_h, exp_v, pos, neg, badw, nreq, dx, dy, m;
    logic [3:0] prev_in, new_in;

    reset = 1'b1; mode = 2'b10; sens = 2'b10; req_valid = 1'b0;
    req_dx = 9'd0; req_dy = 9'd0;
    {v_dir_in, v_clk_in, h_dir_in, h_clk_in} = 4'b0000;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready_low", int'(req_ready), 0);
    check("rst_outs", int'({v_dir_out, v_clk_out, h_dir_out, h_clk_out}), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_acc_h", int'(u_dut.u_h.acc_r), 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", int'(req_ready), 1);

    // Single +3 request: three positive pulses with fixed timing
    h0 = h_n; v0 = v_n;
    send(3, 0);
    a = acc_cyc;
    wait_idle(200, "t1");
    check("t1_count", h_n - h0, 3);
    check_train("t1", 1'b1, h0, h_n, 3, 0);
    for (int i = 0; i < 3; i++) check($sformatf("t1_rise%0d", i), h_rise[h0+i], a + 1 + HALF + 2*HALF*i);
    check("t1_busy_fall", idle_cyc, a + 1 + HALF + 2*HALF*2 + 2*HALF);
    check("t1_v_quiet", v_n - v0, 0);

    // +2 then -5 during the first HIGH: one positive, reversal, four negative
    h0 = h_n;
    send(2, 0);
    a = acc_cyc;
    repeat (4) @(posedge clk);
    send(-5, 0);
    wait_idle(400, "t2");
    check_train("t2", 1'b1, h0, h_n, 1, 4);
    check("t2_rise0", h_rise[h0], a + 1 + HALF);
    check("t2_rise1", h_rise[h0+1], a + 1 + HALF + 3*HALF);
    check("t2_rise2", h_rise[h0+2], a + 1 + HALF + 5*HALF);

    // Quarter sensitivity rounds toward minus infinity
    sens = 2'b00;
    h0 = h_n;
    send(3, 0);
    wait_idle(50, "t3a");
    check("t3_small_pos", h_n - h0, 0);
    h0 = h_n;
    send(-3, 0);
    wait_idle(100, "t3b");
    check_train("t3_small_neg", 1'b1, h0, h_n, 0, 1);

    // Double sensitivity: -100 becomes 200 negative pulses
    sens = 2'b11;
    h0 = h_n;
    send(-100, 0);
    wait_idle(3000, "t3c");
    check_train("t3_double", 1'b1, h0, h_n, 0, 200);

    // Saturation at +511
    h0 = h_n;
    send(255, 0);
    check("sat_first", int'(u_dut.u_h.acc_r), 510);
    send(255, 0);
    check("sat_second", int'(u_dut.u_h.acc_r), 511);
    send(255, 0);
    check("sat_third", int'(u_dut.u_h.acc_r), 511);
    wait_idle(5000, "sat");
    check_train("sat", 1'b1, h0, h_n, 511, 0);

    // Mode change mid-pulse abandons everything
    sens = 2'b10;
    h0 = h_n; v0 = v_n;
    send(5, 3);
    wait_high(100, "t4");
    mode = 2'b01;
    @(negedge clk); #1;
    check("t4_hclk", int'(h_clk_out), 0);
    check("t4_vclk", int'(v_clk_out), 0);
    check("t4_busy", int'(busy), 0);
    check("t4_acc_h", int'(u_dut.u_h.acc_r), 0);
    check("t4_acc_v", int'(u_dut.u_v.acc_r), 0);
    h1 = h_n; v1 = v_n;
    check("t4_h_started", h1 - h0, 1);
    repeat (30) @(negedge clk);
    #1;
    check("t4_h_no_more", h_n - h1, 0);
    check("t4_v_no_more", v_n - v1, 0);

    // SNAC passthrough: one-cycle delayed inputs, requests refused
    mode = 2'b11;
    req_valid = 1'b1; req_dx = 9'd50; req_dy = 9'h1CE;
    #1;
    check("pt_ready", int'(req_ready), 0);
    prev_in = 4'($urandom_range(0, 15));
    {v_dir_in, v_clk_in, h_dir_in, h_clk_in} = prev_in;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); #1;
      check($sformatf("pt_track%0d", i), int'({v_dir_out, v_clk_out, h_dir_out, h_clk_out}), int'(prev_in));
      new_in = 4'($urandom_range(0, 15));
      {v_dir_in, v_clk_in, h_dir_in, h_clk_in} = new_in;
      prev_in = new_in;
    end
    req_valid = 1'b0;
    check("pt_acc_h", int'(u_dut.u_h.acc_r), 0);
    check("pt_acc_v", int'(u_dut.u_v.acc_r), 0);
    check("pt_busy", int'(busy), 0);
    mode = 2'b10;
    repeat (3) @(negedge clk);
    #1;
    check("pt_exit_clks", int'({v_clk_out, h_clk_out}), 0);
    check("pt_exit_busy", int'(busy), 0);

    // Reset during HIGH, then a single v pulse
    send(4, 0);
    wait_high(100, "t6");
    reset = 1'b1;
    @(negedge clk); #1;
    check("t6_outs", int'({v_dir_out, v_clk_out, h_dir_out, h_clk_out}), 0);
    check("t6_acc_h", int'(u_dut.u_h.acc_r), 0);
    check("t6_busy", int'(busy), 0);
    check("t6_ready", int'(req_ready), 0);
    reset = 1'b0;
    h1 = h_n; v1 = v_n;
    send(0, 1);
    wait_idle(200, "t6");
    check_train("t6_v", 1'b0, v1, v_n, 1, 0);
    check("t6_h_quiet", h_n - h1, 0);

    // Randomized request bursts against the net-displacement model
    for (int t = 0; t < 6; t++) begin
      m = $urandom_range(0, 2);
      if (m[1:0] != mode) begin
        @(negedge clk);
        mode = m[1:0];
        repeat (2) @(negedge clk);
      end
      h0 = h_n; v0 = v_n;
      exp_h = 0; exp_v = 0;
      nreq = $urandom_range(1, 4);
      for (int r = 0; r < nreq; r++) begin
        dx = int'($urandom_range(0, 40)) - 20;
        dy = int'($urandom_range(0, 40)) - 20;
        m = $urandom_range(0, 3);
        sens = m[1:0];
        exp_h += scale(dx, m);
        exp_v += scale(dy, m);
        send(dx, dy);
        repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      wait_idle(3000, $sformatf("rnd%0d", t));
      train_stats(1'b1, h0, h_n, pos, neg, badw);
      check($sformatf("rnd%0d_net_h", t), pos - neg, exp_h);
      check($sformatf("rnd%0d_width_h", t), badw, 0);
      train_stats(1'b0, v0, v_n, pos, neg, badw);
      check($sformatf("rnd%0d_net_v", t), pos - neg, exp_v);
      check($sformatf("rnd%0d_width_v", t), badw, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tb_pulse_sched.md
# tb_pulse_sched

Trackball pulse scheduler that sits between the trackball input sources (digital/analog joystick, PS/2 mouse, SNAC trackball) and the game core's quadrature trackball inputs. It accepts signed per-frame movement requests over a valid/ready handshake and scales them by the selected sensitivity. It accumulates them per axis and meters them out as rate-limited clock/direction pulse trains, with an independent engine for each axis. In SNAC mode it gets out of the way and forwards the real trackball lines.

## Interface

Parameters:
- ACC_W, 10: signed per-axis accumulator width; saturates at ±(2^(ACC_W-1)-1).
- HALF, 64: clk cycles per pulse phase (setup, high, low); must be ≥2.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- mode  in  2  00 digital joy, 01 analog joy, 10 mouse, 11 SNAC passthrough
- sens  in  2  00 25%, 01 50%, 10 100%, 11 200%
- req_valid  in  1  delta request present
- req_dx  in  9  signed horizontal delta
- req_dy  in  9  signed vertical delta
- req_ready  out  1  request accepted when valid&ready
- v_dir_in, v_clk_in, h_dir_in, h_clk_in  in  1 each  SNAC trackball lines
- v_dir_out, v_clk_out, h_dir_out, h_clk_out  out  1 each  to game core
- busy  out  1  either axis accumulator nonzero or engine not IDLE

## Operation

- Scaling: arithmetic shift of each delta: sens 00 >>>2, 01 >>>1, 10 unchanged, 11 <<1. Sign-extend to ACC_W before the shift.
- Accept: req_ready = 1 when mode≠11. A transfer occurs on the cycle where req_valid&req_ready. Scaled dx/dy are added to acc_h/acc_v with saturation.
- Per-axis engine states:
  - IDLE: clk_out=0.
  - SETUP: dir_out = (acc>0), clk_out=0.
  - HIGH: clk_out=1.
  - LOW: clk_out=0.
- Each state lasts HALF cycles, counted by a per-engine phase counter.
- Transitions:
  - IDLE→SETUP when acc≠0.
  - SETUP→HIGH.
  - HIGH→LOW.
  - At LOW exit, acc moves one unit toward zero. Then:
    - →IDLE if the new acc is 0.
    - →HIGH if sign(acc) still matches dir_out.
    - otherwise →SETUP (direction reversal).
- Simultaneous accept and LOW-exit decrement on the same cycle: both apply, net = acc + scaled − sign(dir). Saturation is applied once, to the result.
- A request that drives acc across zero takes effect at the next LOW exit (reversal through SETUP).
- Mode change (mode differs from the previous cycle): clear both accumulators, force both engines to IDLE, and drive clk_out=0 on the next cycle. A pulse in progress is abandoned.
- Passthrough (mode=11): outputs are the *_in lines registered by one clk; engines are held IDLE and accumulators at 0; requests are not accepted.
- Reset: acc=0, engines IDLE, phase counters 0. All *_out=0, req_ready=0 during reset, busy=0.

## Timing

- Accept in cycle N → acc updated N+1 → engine enters SETUP N+1 if IDLE, dir_out valid N+1.
- First clk_out rise at N+1+HALF, fall at N+1+2·HALF.
- Same-direction pulse period = 2·HALF. A reversal adds HALF of setup.
- Passthrough latency: 1 cycle.
- req_ready is combinational from mode only; no output depends combinationally on req_valid.
- busy is registered and reflects the state at end of the prior cycle.

## Structure

- Shared package tb_pkg holds:
  - mode_t enum (MODE_DJOY, MODE_AJOY, MODE_MOUSE, MODE_SNAC)
  - axis_state_t enum (IDLE, SETUP, HIGH, LOW)
  - a sens_scale function (9-bit delta, sens → ACC_W result)
  - the saturating-add function
- Sub-module tb_axis_pulser, instantiated once per axis. It owns the accumulator, phase counter and FSM, and exposes add_en, add_val, clear, dir_out, clk_out and busy.
- The top-level block handles the handshake, scaling, mode-change detection, passthrough mux and busy OR.

## Test plan

- Reset, mode=10, sens=10, HALF=4, one request dx=+3, dy=0 → exactly 3 h_clk_out pulses with h_dir_out=1; first rise 5 cycles after accept; busy low after the last LOW; v_clk_out stays 0.
- Request dx=+2 then, during the first HIGH, dx=−5 → 1 more positive pulse, then SETUP with h_dir_out=0, then 4 negative pulses (net −3 after the in-flight decrements).
- sens=00, dx=+3 → 0 pulses. sens=11, dx=−100 → 200 negative pulses. Repeated dx=+255 at sens=11 saturates acc at +511 with no wrap.
- Mid-pulse mode change 10→01 → next cycle both clk_out=0, busy=0, and no further pulses.
- mode=11, toggle h_clk_in/v_dir_in arbitrarily → outputs track the inputs delayed 1 cycle; req_ready=0; queued requests are ignored.
- Assert reset during a HIGH phase → next cycle all outputs 0 and acc=0. After release, a new dy=+1 yields exactly one v pulse.
